// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-through / no-write-allocate data cache controller driving a dual-port cache SRAM.
// Optional invalidation walk compiled in with `define DCACHE_FLUSH_EN.
module dcache_ctrl #(
    parameter int INDEX_W    = 9,
    parameter int TAG_W      = 32 - 4 - INDEX_W,
    parameter int LINE_W     = 148,
    parameter int NUM_WMASKS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // core request / response
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    // cache SRAM
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [INDEX_W-1:0]    sram_addr0,
    output logic [LINE_W-1:0]     sram_din0,
    input  logic [LINE_W-1:0]     sram_dout0,
    output logic                  sram_csb1,
    output logic [INDEX_W-1:0]    sram_addr1,
    // backing memory
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [31:0]           mem_req_addr,
    output logic [31:0]           mem_req_wdata,
    output logic [3:0]            mem_req_be,
    input  logic                  mem_resp_valid,
    input  logic [127:0]          mem_resp_data,
    // invalidation walk
    input  logic                  flush_req,
    output logic                  flush_busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid is never withdrawn and its payload never changes until then.
    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_FILL_WR,
        S_STORE_WR,
        S_WT_REQ,
        S_WT_WAIT
`ifdef DCACHE_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [127:0]  line_q, line_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         word_sel;
    logic               hit;

`ifdef DCACHE_FLUSH_EN
    logic [INDEX_W-1:0] flush_idx_q, flush_idx_d;
`else
    logic unused_flush_req;
    assign unused_flush_req = flush_req;
`endif

    function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] ws);
        return line[{ws, 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] merge_store(input logic [127:0] line, input logic [1:0] ws,
                                                 input logic [31:0] wd, input logic [3:0] be);
        logic [127:0] m;
        m = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[{ws, 5'b0} + b * 8 +: 8] = wd[b * 8 +: 8];
        end
        return m;
    endfunction

    assign req_tag   = addr_q[31:INDEX_W+4];
    assign req_index = addr_q[INDEX_W+3:4];
    assign word_sel  = addr_q[3:2];
    assign hit       = sram_dout0[LINE_W-1] && (sram_dout0[LINE_W-2 -: TAG_W] == req_tag);

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign sram_csb1  = 1'b1;
    assign sram_addr1 = '0;

`ifdef DCACHE_FLUSH_EN
    assign flush_busy = (state_q == S_FLUSH);
`else
    assign flush_busy = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        line_d        = line_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        req_ready     = 1'b0;
        sram_csb0     = 1'b1;
        sram_web0     = 1'b1;
        sram_wmask0   = '0;
        sram_addr0    = '0;
        sram_din0     = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_be    = '0;
`ifdef DCACHE_FLUSH_EN
        flush_idx_d   = flush_idx_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef DCACHE_FLUSH_EN
                // A pending flush wins; the core is held off so no request is dropped.
                if (flush_req) begin
                    flush_idx_d = '0;
                    state_d     = S_FLUSH;
                end else
`endif
                begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        addr_d     = req_addr;
                        we_d       = req_we;
                        wdata_d    = req_wdata;
                        be_d       = req_be;
                        sram_csb0  = 1'b0;
                        sram_addr0 = req_addr[INDEX_W+3:4];
                        state_d    = S_LOOKUP;
                    end
                end
            end

            S_LOOKUP: begin
                if (hit) begin
                    if (we_q) begin
                        line_d  = merge_store(sram_dout0[127:0], word_sel, wdata_q, be_q);
                        state_d = S_STORE_WR;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = sel_word(sram_dout0[127:0], word_sel);
                        state_d      = S_IDLE;
                    end
                end else begin
                    state_d = we_q ? S_WT_REQ : S_REFILL_REQ;
                end
            end

            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[31:4], 4'b0};
                if (mem_req_ready) state_d = S_REFILL_WAIT;
            end

            S_REFILL_WAIT: begin
                // Response is registered so it lines up with the fill write cycle.
                if (mem_resp_valid) begin
                    line_d       = mem_resp_data;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = sel_word(mem_resp_data, word_sel);
                    state_d      = S_FILL_WR;
                end
            end

            S_FILL_WR, S_STORE_WR: begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = req_index;
                sram_din0   = {1'b1, req_tag, line_q};
                state_d     = (state_q == S_FILL_WR) ? S_IDLE : S_WT_REQ;
            end

            S_WT_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_wdata = wdata_q;
                mem_req_be    = be_q;
                if (mem_req_ready) state_d = S_WT_WAIT;
            end

            S_WT_WAIT: begin
                if (mem_resp_valid) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end

`ifdef DCACHE_FLUSH_EN
            S_FLUSH: begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = flush_idx_q;
                flush_idx_d = flush_idx_q + 1'b1;
                if (flush_idx_q == {INDEX_W{1'b1}}) state_d = S_IDLE;
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            line_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
`ifdef DCACHE_FLUSH_EN
            flush_idx_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            line_q       <= line_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef DCACHE_FLUSH_EN
            flush_idx_q  <= flush_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural cache SRAM, stallable backing memory,
// scoreboard of hand-computed expectations for miss/hit/store/reset/flush scenarios.
module tb_dcache_ctrl;
  localparam int INDEX_W    = 9;
  localparam int TAG_W      = 19;
  localparam int LINE_W     = 148;
  localparam int NUM_WMASKS = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  req_valid, req_ready, req_we;
  logic [31:0]           req_addr, req_wdata;
  logic [3:0]            req_be;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  sram_csb0, sram_web0, sram_csb1;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [INDEX_W-1:0]    sram_addr0, sram_addr1;
  logic [LINE_W-1:0]     sram_din0, sram_dout0;
  logic                  mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]           mem_req_addr, mem_req_wdata;
  logic [3:0]            mem_req_be;
  logic                  mem_resp_valid;
  logic [127:0]          mem_resp_data;
  logic                  flush_req, flush_busy;

  dcache_ctrl #(
    .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .NUM_WMASKS(NUM_WMASKS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  // ---------------- cache SRAM model (zero-initialised) ----------------
  logic [LINE_W-1:0] sram_mem [0:(1<<INDEX_W)-1] = '{default: '0};
  int sram_wr_cnt = 0;

  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        if (sram_wmask0 == '1) sram_mem[sram_addr0] <= sram_din0;
        sram_wr_cnt <= sram_wr_cnt + 1;
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  // ---------------- backing memory model ----------------
  int           mem_stall = 0;
  logic [127:0] refill_line = '0;
  logic         inject_resp = 1'b0;
  logic         resp_r;
  logic         pending;
  int           wcnt;
  int           mem_req_cnt = 0;
  logic [31:0]  log_addr = '0, log_wdata = '0;
  logic         log_we = 1'b0;
  logic [3:0]   log_be = '0;

  assign mem_resp_valid = resp_r | inject_resp;
  assign mem_resp_data  = refill_line;

  initial begin
    mem_req_ready = 1'b0;
    resp_r  = 1'b0;
    pending = 1'b0;
    wcnt    = 0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      resp_r        = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        wcnt    = 0;
      end else if (pending) begin
        resp_r  = 1'b1;
        pending = 1'b0;
      end else if (mem_req_valid) begin
        if (wcnt < mem_stall) begin
          wcnt++;
        end else begin
          mem_req_ready = 1'b1;
          wcnt          = 0;
          pending       = 1'b1;
          mem_req_cnt++;
          log_addr  = mem_req_addr;
          log_we    = mem_req_we;
          log_wdata = mem_req_wdata;
          log_be    = mem_req_be;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Backing-memory request must stay up and unchanged until accepted.
  int          hold_err = 0;
  logic        hold_pend = 1'b0;
  logic [68:0] hold_pay = '0;
  always @(posedge clk) begin
    if (hold_pend && rst_n &&
        (!mem_req_valid || {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be} != hold_pay))
      hold_err++;
    hold_pend = mem_req_valid && !mem_req_ready && rst_n;
    hold_pay  = {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be};
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic last_ready;

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    lat = 1;
    while (!resp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", resp_valid, 1'b1);
    rdata      = resp_rdata;
    last_ready = req_ready;
    @(negedge clk);
    check("resp_pulse", resp_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0]  rd;
  int           lat, c0, w0, cnt;
  logic [127:0] line_a;

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    flush_req = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_csb0", sram_csb0, 1'b1);
    check("rst_web0", sram_web0, 1'b1);
    check("rst_csb1", sram_csb1, 1'b1);
    check("rst_addr1", sram_addr1, 9'h0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_flush_busy", flush_busy, 1'b0);
    rst_n = 1'b1;

    // load miss + refill
    line_a = {32'h33333333, 32'h22222222, 32'hCAFEBABE, 32'h11110000};
    refill_line = line_a;
    c0 = mem_req_cnt;
    do_req(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd, lat);
    check("miss_rdata", rd, 32'hCAFEBABE);
    check("miss_mem_cnt", mem_req_cnt - c0, 1);
    check("miss_mem_we", log_we, 1'b0);
    check("miss_mem_addr", log_addr, 32'h0000_1230);
    check("fill_line", sram_mem[9'h123], {1'b1, 19'h0, line_a});

    // load hit
    refill_line = '1;
    c0 = mem_req_cnt;
    do_req(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd, lat);
    check("hit_rdata", rd, 32'hCAFEBABE);
    check("hit_latency", lat, 2);
    check("hit_ready_back", last_ready, 1'b1);
    check("hit_no_mem", mem_req_cnt - c0, 0);

    // store hit with a slow memory
    mem_stall = 3;
    c0 = mem_req_cnt;
    w0 = sram_wr_cnt;
    do_req(1'b1, 32'h0000_1234, 32'h11223344, 4'b0011, rd, lat);
    check("st_line", sram_mem[9'h123],
          {1'b1, 19'h0, 32'h33333333, 32'h22222222, 32'hCAFE3344, 32'h11110000});
    check("st_sram_wr", sram_wr_cnt - w0, 1);
    check("st_mem_cnt", mem_req_cnt - c0, 1);
    check("st_mem_we", log_we, 1'b1);
    check("st_mem_addr", log_addr, 32'h0000_1234);
    check("st_mem_wdata", log_wdata, 32'h11223344);
    check("st_mem_be", log_be, 4'b0011);
    mem_stall = 0;

    do_req(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd, lat);
    check("st_reload", rd, 32'hCAFE3344);
    check("st_reload_lat", lat, 2);
    do_req(1'b0, 32'h0000_123C, 32'h0, 4'h0, rd, lat);
    check("word3", rd, 32'h33333333);
    do_req(1'b0, 32'h0000_1230, 32'h0, 4'h0, rd, lat);
    check("word0", rd, 32'h11110000);

    // store miss: write-through only
    c0 = mem_req_cnt;
    w0 = sram_wr_cnt;
    do_req(1'b1, 32'h0000_8000, 32'hDEADBEEF, 4'b1111, rd, lat);
    check("stm_no_sram", sram_wr_cnt - w0, 0);
    check("stm_mem_cnt", mem_req_cnt - c0, 1);
    check("stm_mem_we", log_we, 1'b1);
    check("stm_mem_addr", log_addr, 32'h0000_8000);
    check("stm_mem_wdata", log_wdata, 32'hDEADBEEF);

    line_a = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h5555AAAA};
    refill_line = line_a;
    c0 = mem_req_cnt;
    do_req(1'b0, 32'h0000_8000, 32'h0, 4'h0, rd, lat);
    check("ldm_mem_cnt", mem_req_cnt - c0, 1);
    check("ldm_mem_addr", log_addr, 32'h0000_8000);
    check("ldm_rdata", rd, 32'h5555AAAA);
    check("ldm_fill", sram_mem[9'h000], {1'b1, 19'd4, line_a});

    // reset in the middle of a stalled refill
    mem_stall = 1000;
    c0 = mem_req_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000;
    @(negedge clk);
    req_valid = 1'b0; req_addr = '0;
    cnt = 0;
    while (!mem_req_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    repeat (5) @(negedge clk);
    check("rf_stalled", mem_req_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_req_ready", req_ready, 1'b1);
    check("mr_resp_valid", resp_valid, 1'b0);
    check("mr_resp_rdata", resp_rdata, 32'h0);
    check("mr_csb0", sram_csb0, 1'b1);
    check("mr_web0", sram_web0, 1'b1);
    check("mr_wmask0", sram_wmask0, 16'h0);
    check("mr_addr0", sram_addr0, 9'h0);
    check("mr_din0", sram_din0, 148'h0);
    check("mr_mem_valid", mem_req_valid, 1'b0);
    check("mr_mem_addr", mem_req_addr, 32'h0);
    check("mr_mem_we", mem_req_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_stall = 0;
    @(negedge clk);
    inject_resp = 1'b1;
    @(negedge clk);
    inject_resp = 1'b0;
    check("late_resp_ignored", resp_valid, 1'b0);
    check("late_mem_idle", mem_req_valid, 1'b0);
    check("late_ready", req_ready, 1'b1);
    @(negedge clk);
    check("late_resp_ignored2", resp_valid, 1'b0);
    check("late_no_mem", mem_req_cnt - c0, 0);

    do_req(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd, lat);
    check("post_rst_hit", rd, 32'hCAFE3344);
    check("post_rst_lat", lat, 2);

`ifdef DCACHE_FLUSH_EN
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    check("fl_ready_low", req_ready, 1'b0);
    cnt = 0;
    while (flush_busy && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check("fl_busy_cycles", cnt, 1 << INDEX_W);
    check("fl_line_cleared", sram_mem[9'h123], 148'h0);
    line_a = {32'h44444444, 32'h33333333, 32'h0F0F1234, 32'h11111111};
    refill_line = line_a;
    c0 = mem_req_cnt;
    do_req(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd, lat);
    check("fl_remiss_cnt", mem_req_cnt - c0, 1);
    check("fl_remiss_rdata", rd, 32'h0F0F1234);
`else
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    check("nofl_busy", flush_busy, 1'b0);
    c0 = mem_req_cnt;
    do_req(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd, lat);
    check("nofl_hit", rd, 32'hCAFE3344);
    check("nofl_no_mem", mem_req_cnt - c0, 0);
`endif

    check("mem_req_hold", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
